// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared types for the key event scheduler.
// Rev 1.0
`default_nettype none

package key_sched_pkg;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  localparam logic [7:0] KEY_PAUSE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: show-ahead synchronous FIFO of key events with flush.
// Rev 1.0
`default_nettype none

module key_evt_fifo
  import key_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  key_evt_t               din,
  output key_evt_t               dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // The extra count bit separates full from empty when the pointers coincide.
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && reset_n && !flush) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/key_event_sched.sv
// key_event_sched: merges live PS/2 events with paced injected events into one strobe stream.
// Rev 1.0
`default_nettype none

module key_event_sched
  import key_sched_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         HOLD_CYCLES = 7000000,
  parameter logic [7:0] ABORT_CODE  = 8'h76
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [10:0]                 ps2_key,
  input  logic                        inj_valid,
  input  logic [8:0]                  inj_data,
  output logic                        inj_ready,
  output logic                        out_strobe,
  output logic                        out_press,
  output logic [7:0]                  out_code,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        aborted
);

  sched_state_t state;
  sched_state_t state_nxt;
  logic [31:0]  cnt;
  logic         old_toggle;
  logic         live_pend;
  logic         abort_now;
  logic         hold_done;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         emit_inj;
  logic         emit_rel;
  key_evt_t     inj_evt;
  key_evt_t     head;
  key_evt_t     cur_evt;
  logic [7:0]   last_code;
  logic         last_press;

  assign inj_evt   = inj_data;
  assign live_pend = (ps2_key[10] != old_toggle);
  assign busy      = !fifo_empty || (state != IDLE);
  assign abort_now = live_pend && ps2_key[9] && !ps2_key[8] &&
                     (ps2_key[7:0] == ABORT_CODE) && busy;
  assign inj_ready = !fifo_full;
  assign push      = inj_valid && !fifo_full && !abort_now;
  assign hold_done = (cnt == 32'(HOLD_CYCLES - 2));

  key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (abort_now),
    .din     (inj_evt),
    .dout    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // The last HOLD cycle makes the IDLE decision itself, so a non-empty FIFO
  // keeps issue-to-issue spacing at exactly HOLD_CYCLES.
  always_comb begin
    state_nxt = state;
    if (abort_now) begin
      state_nxt = last_press ? RELEASE : IDLE;
    end else begin
      case (state)
        IDLE:    if (pop) state_nxt = ISSUE;
        ISSUE:   if (!live_pend) state_nxt = HOLD;
        HOLD:    if (hold_done) state_nxt = pop ? ISSUE : IDLE;
        RELEASE: if (!live_pend) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pop      = ((state == IDLE) || ((state == HOLD) && hold_done)) &&
               !fifo_empty && !live_pend;
    emit_inj = (state == ISSUE) && !live_pend && (cur_evt.code != KEY_PAUSE);
    emit_rel = (state == RELEASE) && !live_pend;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt        <= '0;
      cur_evt    <= '0;
      last_code  <= '0;
      last_press <= 1'b0;
      old_toggle <= ps2_key[10];
      out_strobe <= 1'b0;
      out_press  <= 1'b0;
      out_code   <= '0;
      aborted    <= 1'b0;
    end else begin
      old_toggle <= ps2_key[10];
      if (pop) cur_evt <= head;
      if ((state == HOLD) && (state_nxt == HOLD)) cnt <= cnt + 32'd1;
      else                                        cnt <= '0;

      out_strobe <= live_pend || emit_inj || emit_rel;
      if (live_pend)     {out_press, out_code} <= {ps2_key[9], ps2_key[7:0]};
      else if (emit_inj) {out_press, out_code} <= {cur_evt.press, cur_evt.code};
      else if (emit_rel) {out_press, out_code} <= {1'b0, last_code};

      if (emit_inj) begin
        last_code  <= cur_evt.code;
        last_press <= cur_evt.press;
      end else if (emit_rel) begin
        last_press <= 1'b0;
      end

      if (abort_now) aborted <= 1'b1;
      else if (push) aborted <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_event_sched.sv
// tb_key_event_sched: vector table, directed corner sequences and random run vs a timing model.
`default_nettype none

module tb_key_event_sched;

  localparam int HOLD  = 10;
  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        inj_valid;
  logic [8:0]  inj_data;
  logic        inj_ready;
  logic        out_strobe;
  logic        out_press;
  logic [7:0]  out_code;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        aborted;

  key_event_sched #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .ABORT_CODE(8'h76)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .inj_valid  (inj_valid),
    .inj_data   (inj_data),
    .inj_ready  (inj_ready),
    .out_strobe (out_strobe),
    .out_press  (out_press),
    .out_code   (out_code),
    .busy       (busy),
    .fifo_count (fifo_count),
    .aborted    (aborted)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: time-based view of the scheduling rules.
  logic [8:0] mq[$];
  logic       m_armed, m_rel, m_last_press, m_old, m_aborted, m_strobe, m_press;
  logic [8:0] m_cur;
  logic [7:0] m_last_code, m_code;
  int         m_gate;
  int         edge_n = 0;

  typedef struct {int t; logic p; logic [7:0] c;} slog_t;
  slog_t slog[$];

  task automatic model_edge();
    logic live, abrt, mbusy, acc;
    edge_n++;
    if (!reset_n) begin
      mq.delete();
      m_armed = 0; m_rel = 0; m_gate = 0; m_last_press = 0; m_last_code = 0;
      m_old = ps2_key[10]; m_aborted = 0; m_strobe = 0; m_press = 0; m_code = 0;
      return;
    end
    live  = (ps2_key[10] !== m_old);
    m_old = ps2_key[10];
    mbusy = (mq.size() > 0) || m_armed || m_rel || (edge_n <= m_gate);
    abrt  = live && ps2_key[9] && !ps2_key[8] && (ps2_key[7:0] == 8'h76) && mbusy;
    acc   = inj_valid && (mq.size() < DEPTH) && !abrt;
    m_strobe = 0;
    if (live) begin m_strobe = 1; m_press = ps2_key[9]; m_code = ps2_key[7:0]; end
    if (abrt) begin
      mq.delete(); m_armed = 0; m_gate = 0; m_rel = m_last_press; m_aborted = 1;
    end else if (m_rel) begin
      if (!live) begin
        m_strobe = 1; m_press = 0; m_code = m_last_code; m_last_press = 0; m_rel = 0;
      end
    end else if (m_armed) begin
      if (!live) begin
        if (m_cur[7:0] != 8'h00) begin
          m_strobe = 1; m_press = m_cur[8]; m_code = m_cur[7:0];
          m_last_press = m_cur[8]; m_last_code = m_cur[7:0];
        end
        m_armed = 0;
        m_gate  = edge_n + HOLD - 1;   // earliest edge at which the next entry may be taken
      end
    end else if ((mq.size() > 0) && !live && (edge_n >= m_gate)) begin
      m_cur = mq.pop_front(); m_armed = 1;
    end
    if (acc) begin mq.push_back(inj_data); m_aborted = 0; end
  endtask

  task automatic step();
    logic [15:0] act, exp;
    logic        mb;
    model_edge();
    @(posedge clk_sys);
    #1;
    mb  = (mq.size() > 0) || m_armed || m_rel || (edge_n < m_gate);
    act = {out_strobe, out_press, out_code, busy, inj_ready, fifo_count, aborted};
    exp = {m_strobe, m_press, m_code, mb, 1'(mq.size() < DEPTH), 3'(mq.size()), m_aborted};
    check($sformatf("model@%0d", edge_n), 32'(act), 32'(exp));
    if (out_strobe) slog.push_back('{edge_n, out_press, out_code});
  endtask

  task automatic push(input logic [8:0] d);
    inj_valid = 1'b1; inj_data = d;
    step();
    inj_valid = 1'b0;
  endtask

  task automatic live(input logic p, input logic ext, input logic [7:0] c);
    logic t;
    t = ~ps2_key[10];
    ps2_key = {t, p, ext, c};
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    do begin step(); n++; end while (busy && n < max);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_log(input int sz, input int max);
    int n = 0;
    while (slog.size() < sz && n < max) begin step(); n++; end
    check("strobe_timeout", 32'(slog.size() >= sz), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; step(); step(); reset_n = 1'b1;
  endtask

  typedef struct {
    logic tog; logic prs; logic [7:0] code; logic iv; logic [8:0] id;
    logic e_stb; logic e_prs; logic [7:0] e_code; logic [2:0] e_cnt; logic e_rdy;
  } vec_t;
  vec_t vt[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset_n = 1'b0; ps2_key = '0; inj_valid = 1'b0; inj_data = '0;
    do_reset();
    check("reset_state", 32'({out_strobe, out_press, out_code, fifo_count, aborted, busy, inj_ready}),
          32'({1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1}));

    // Live-only events, then backpressure: live traffic every cycle blocks pops.
    vt[0] = '{1'b1, 1'b1, 8'h1c, 1'b0, 9'h000, 1'b1, 1'b1, 8'h1c, 3'd0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 8'h1c, 1'b0, 9'h000, 1'b0, 1'b1, 8'h1c, 3'd0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 8'h1c, 1'b1, 9'h13b, 1'b1, 1'b0, 8'h1c, 3'd1, 1'b1};
    vt[3] = '{1'b1, 1'b1, 8'h11, 1'b1, 9'h03b, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1};
    vt[4] = '{1'b0, 1'b0, 8'h11, 1'b1, 9'h121, 1'b1, 1'b0, 8'h11, 3'd3, 1'b1};
    vt[5] = '{1'b1, 1'b1, 8'h12, 1'b1, 9'h021, 1'b1, 1'b1, 8'h12, 3'd4, 1'b0};
    vt[6] = '{1'b0, 1'b0, 8'h12, 1'b1, 9'h199, 1'b1, 1'b0, 8'h12, 3'd4, 1'b0};
    vt[7] = '{1'b0, 1'b0, 8'h12, 1'b0, 9'h000, 1'b0, 1'b0, 8'h12, 3'd3, 1'b1};
    vt[8] = '{1'b0, 1'b0, 8'h12, 1'b0, 9'h000, 1'b1, 1'b1, 8'h3b, 3'd3, 1'b1};
    for (int i = 0; i < 9; i++) begin
      ps2_key = {vt[i].tog, vt[i].prs, 1'b0, vt[i].code};
      inj_valid = vt[i].iv; inj_data = vt[i].id;
      step();
      check($sformatf("vec%0d", i), 32'({out_strobe, out_press, out_code, fifo_count, inj_ready}),
            32'({vt[i].e_stb, vt[i].e_prs, vt[i].e_code, vt[i].e_cnt, vt[i].e_rdy}));
    end
    inj_valid = 1'b0;
    do_reset();

    // Paced injection: strobes HOLD apart, busy drops HOLD-1 edges after the last issue.
    slog.delete();
    push(9'h13b); push(9'h03b);
    wait_log(2, 40);
    if (slog.size() >= 2) begin
      check("paced_gap", 32'(slog[1].t - slog[0].t), 32'(HOLD));
      check("paced_evts", 32'({slog[0].p, slog[0].c, slog[1].p, slog[1].c}), 32'({1'b1, 8'h3b, 1'b0, 8'h3b}));
      t0 = slog[1].t;
      repeat (HOLD - 2) step();
      check("busy_hold", 32'(busy), 32'd1);
      step();
      check("busy_fall", 32'({busy, 32'(edge_n - t0) == 32'(HOLD - 1)}), 32'({1'b0, 1'b1}));
    end

    // Pause entry produces no strobe but still takes a hold slot.
    slog.delete();
    push(9'h152); push(9'h000); push(9'h052);
    run_idle(60);
    check("pause_count", 32'(slog.size()), 32'd2);
    if (slog.size() == 2) begin
      check("pause_gap", 32'(slog[1].t - slog[0].t), 32'(2 * HOLD));
      check("pause_evts", 32'({slog[0].p, slog[0].c, slog[1].p, slog[1].c}), 32'({1'b1, 8'h52, 1'b0, 8'h52}));
    end

    // Collision: live event lands on the edge the second injected issue is due.
    slog.delete();
    push(9'h13b); push(9'h144);
    wait_log(1, 20);
    repeat (HOLD - 1) step();
    live(1'b1, 1'b0, 8'h1c);
    step();
    run_idle(40);
    check("coll_count", 32'(slog.size()), 32'd3);
    if (slog.size() == 3) begin
      check("coll_live", 32'({32'(slog[1].t - slog[0].t), slog[1].p, slog[1].c}), 32'({32'(HOLD), 1'b1, 8'h1c}));
      check("coll_inj", 32'({32'(slog[2].t - slog[0].t), slog[2].p, slog[2].c}), 32'({32'(HOLD + 1), 1'b1, 8'h44}));
    end

    // Abort: ESC during HOLD after a press, then an auto-release of that key.
    slog.delete();
    push(9'h15a); push(9'h166);
    wait_log(1, 20);
    repeat (3) step();
    live(1'b1, 1'b0, 8'h76);
    step();
    check("abort_flush", 32'({fifo_count, aborted}), 32'({3'd0, 1'b1}));
    step();
    check("abort_count", 32'(slog.size()), 32'd3);
    if (slog.size() == 3) begin
      check("abort_esc", 32'({32'(slog[1].t - slog[0].t), slog[1].p, slog[1].c}), 32'({32'd4, 1'b1, 8'h76}));
      check("abort_rel", 32'({32'(slog[2].t - slog[0].t), slog[2].p, slog[2].c}), 32'({32'd5, 1'b0, 8'h5a}));
    end
    check("aborted_sticky", 32'(aborted), 32'd1);
    push(9'h13b);
    check("aborted_clear", 32'(aborted), 32'd0);
    run_idle(40);

    // Reset in the middle of HOLD drops everything and issues no release.
    push(9'h13b); push(9'h121);
    slog.delete();
    wait_log(1, 20);
    repeat (3) step();
    reset_n = 1'b0;
    step();
    check("reset_midhold", 32'({out_strobe, out_press, out_code, fifo_count, aborted, busy, inj_ready}),
          32'({1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1}));
    reset_n = 1'b1;
    slog.delete();
    repeat (30) step();
    check("reset_quiet", 32'(slog.size()), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        live(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0) ? 8'h76 : 8'($urandom));
      inj_valid = ($urandom_range(0, 2) == 0);
      inj_data  = {1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom)};
      reset_n   = ($urandom_range(0, 499) != 0);
      step();
    end
    reset_n = 1'b1; inj_valid = 1'b0;
    run_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
